// File: rtl/dac_scale_ramp_if.sv
// Simple AXI-Stream style handshake bundle: valid/ready plus a data word.
// The Master_Simple side drives data and valid; the Slave_Simple side drives ready.
interface Axis_If #(
  parameter int WIDTH = 8
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport Master_Simple (
    output valid,
    output data,
    input  ready
  );

  modport Slave_Simple (
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/dac_scale_ramp.sv
// Steps the DAC prescaler scale factor toward a commanded target gain,
// one bounded step per interval, so amplitude changes stay gradual.
module dac_scale_ramp #(
  parameter int SCALE_WIDTH    = 18,
  parameter int STEP_WIDTH     = 18,
  parameter int INTERVAL_WIDTH = 16,
  parameter logic signed [SCALE_WIDTH-1:0] RESET_SCALE = 18'sh10000
) (
  input  logic          clk,
  input  logic          reset,
  Axis_If.Slave_Simple  ramp_cfg,
  Axis_If.Master_Simple scale_factor,
  output logic          busy,
  output logic          ramp_done
);

  localparam int DW = SCALE_WIDTH + 1;
  localparam int CW = ((DW > STEP_WIDTH) ? DW : STEP_WIDTH) + 1;

  localparam logic [1:0] INIT = 2'd0;
  localparam logic [1:0] IDLE = 2'd1;
  localparam logic [1:0] EMIT = 2'd2;
  localparam logic [1:0] WAIT = 2'd3;

  typedef logic signed [SCALE_WIDTH-1:0] scale_t;
  typedef logic [STEP_WIDTH-1:0]         step_t;
  typedef logic [INTERVAL_WIDTH-1:0]     ivl_t;

  // The +/- step result lies strictly between cur and tgt, so it fits.
  function automatic scale_t step_toward(
    input scale_t cur,
    input scale_t tgt,
    input step_t  stp
  );
    logic signed [DW-1:0] diff;
    logic [CW-1:0]        mag;
    diff = DW'(tgt) - DW'(cur);
    mag  = CW'($unsigned(diff[DW-1] ? -diff : diff));
    if (stp == '0 || mag <= CW'(stp))
      return tgt;
    if (diff[DW-1])
      return cur - scale_t'(stp);
    return cur + scale_t'(stp);
  endfunction

  logic [1:0] state;
  scale_t     current;
  scale_t     next_q;
  scale_t     target;
  step_t      step;
  ivl_t       interval;
  ivl_t       cnt;
  logic       done;

  scale_t c_target;
  step_t  c_step;
  ivl_t   c_interval;
  scale_t cmd_next;
  scale_t wait_next;
  scale_t emit_next;
  logic   cfg_fire;
  logic   sf_fire;

  assign c_target   = ramp_cfg.data[SCALE_WIDTH-1:0];
  assign c_step     = ramp_cfg.data[SCALE_WIDTH +: STEP_WIDTH];
  assign c_interval = ramp_cfg.data[SCALE_WIDTH+STEP_WIDTH +: INTERVAL_WIDTH];

  assign cmd_next  = step_toward(current, c_target, c_step);
  assign wait_next = step_toward(current, target, step);
  assign emit_next = step_toward(next_q, target, step);

  assign ramp_cfg.ready     = (state == IDLE) || (state == WAIT);
  assign scale_factor.valid = (state == INIT) || (state == EMIT);
  assign scale_factor.data  = next_q;
  assign busy               = (state != IDLE);
  assign ramp_done          = done;

  assign cfg_fire = ramp_cfg.valid && ramp_cfg.ready;
  assign sf_fire  = scale_factor.valid && scale_factor.ready;

  // WAIT lasts interval-1 cycles so the next valid lands interval cycles
  // after the handshake; intervals of 0 or 1 chain EMIT directly.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= INIT;
      current  <= RESET_SCALE;
      next_q   <= RESET_SCALE;
      target   <= RESET_SCALE;
      step     <= '0;
      interval <= '0;
      cnt      <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        INIT: begin
          if (sf_fire) begin
            current <= next_q;
            state   <= IDLE;
          end
        end
        IDLE: begin
          if (cfg_fire) begin
            target   <= c_target;
            step     <= c_step;
            interval <= c_interval;
            if (c_target != current) begin
              next_q <= cmd_next;
              state  <= EMIT;
            end
          end
        end
        EMIT: begin
          if (sf_fire) begin
            current <= next_q;
            if (next_q == target) begin
              done  <= 1'b1;
              state <= IDLE;
            end else if (interval <= ivl_t'(1)) begin
              next_q <= emit_next;
            end else begin
              cnt   <= interval - ivl_t'(2);
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cfg_fire) begin
            target   <= c_target;
            step     <= c_step;
            interval <= c_interval;
            if (c_target == current) begin
              state <= IDLE;
            end else begin
              next_q <= cmd_next;
              state  <= EMIT;
            end
          end else if (cnt == '0) begin
            next_q <= wait_next;
            state  <= EMIT;
          end else begin
            cnt <= cnt - ivl_t'(1);
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_scale_ramp.sv
// Directed bench for dac_scale_ramp: table of ramp commands with
// hand-computed outputs, plus retarget, backpressure and reset sequences.
module tb_dac_scale_ramp;

  logic clk = 1'b0;
  logic reset;
  logic busy;
  logic ramp_done;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  Axis_If #(.WIDTH(52)) cfg ();
  Axis_If #(.WIDTH(18)) sf ();

  dac_scale_ramp dut (
    .clk          (clk),
    .reset        (reset),
    .ramp_cfg     (cfg),
    .scale_factor (sf),
    .busy         (busy),
    .ramp_done    (ramp_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int target;
    int step;
    int interval;
    int n;
    int gap;
    int exp[4];
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int sdata();
    return int'($signed(sf.data));
  endfunction

  // Presents a command at a negedge; returns one cycle later (t+1).
  task automatic send(input int tgt, input int stp, input int itv);
    cfg.data  = {16'(itv), 18'(stp), 18'(tgt)};
    cfg.valid = 1'b1;
    chk("cfg_ready", int'(cfg.ready), 1);
    @(negedge clk);
    cfg.valid = 1'b0;
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    int   got;
    int   last;
    int   wd;
    int   seen;
    v = vecs[idx];
    send(v.target, v.step, v.interval);
    if (v.n == 0) begin
      seen = 0;
      repeat (6) begin
        if (sf.valid || ramp_done) seen++;
        @(negedge clk);
      end
      chk("noop_quiet", seen, 0);
      chk("noop_busy", int'(busy), 0);
    end else begin
      got  = 0;
      last = cyc - 1;
      wd   = 0;
      while (got < v.n && wd < 300) begin
        if (sf.valid) begin
          chk("vec_data", sdata(), v.exp[got]);
          chk("vec_gap", cyc - last, (got == 0) ? 1 : v.gap);
          chk("vec_early_done", int'(ramp_done), 0);
          last = cyc;
          got++;
        end
        @(negedge clk);
        wd++;
      end
      chk("vec_count", got, v.n);
      chk("vec_done", int'(ramp_done), 1);
      chk("vec_busy", int'(busy), 0);
      @(negedge clk);
      chk("vec_done_clr", int'(ramp_done), 0);
    end
  endtask

  initial begin
    int seen;
    int h;
    int wd;
    int bad;

    vecs[0] = '{32768, 8192, 4, 4, 4, '{57344, 49152, 40960, 32768}};
    vecs[1] = '{-65536, 40000, 1, 3, 1, '{-7232, -47232, -65536, 0}};
    vecs[2] = '{32768, 0, 0, 1, 1, '{32768, 0, 0, 0}};
    vecs[3] = '{32768, 0, 0, 0, 1, '{0, 0, 0, 0}};
    vecs[4] = '{65536, 10000, 0, 4, 1, '{42768, 52768, 62768, 65536}};

    reset     = 1'b1;
    cfg.valid = 1'b0;
    cfg.data  = '0;
    sf.ready  = 1'b1;
    repeat (3) @(negedge clk);

    chk("rst_valid", int'(sf.valid), 1);
    chk("rst_data", sdata(), 65536);
    chk("rst_busy", int'(busy), 1);
    chk("rst_cfg_ready", int'(cfg.ready), 0);
    chk("rst_done", int'(ramp_done), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("init_idle_busy", int'(busy), 0);
    chk("init_idle_ready", int'(cfg.ready), 1);
    seen = 0;
    repeat (5) begin
      if (sf.valid || ramp_done) seen++;
      @(negedge clk);
    end
    chk("init_single_xfer", seen, 0);

    for (int i = 0; i < 5; i++) run_vec(i);

    // Retarget during WAIT: current is 65536 here
    send(0, 16384, 8);
    chk("rt_first_valid", int'(sf.valid), 1);
    chk("rt_first_data", sdata(), 49152);
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (sf.valid) seen++;
    end
    chk("rt_wait_quiet", seen, 0);
    send(65536, 16384, 8);
    chk("rt_valid", int'(sf.valid), 1);
    chk("rt_data", sdata(), 65536);
    @(negedge clk);
    chk("rt_done", int'(ramp_done), 1);
    chk("rt_valid_off", int'(sf.valid), 0);

    // Backpressure on first output, spacing from the real handshake
    send(0, 32768, 5);
    sf.ready = 1'b0;
    chk("bp_valid", int'(sf.valid), 1);
    chk("bp_data", sdata(), 32768);
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (!sf.valid || sdata() != 32768 || ramp_done) bad++;
    end
    @(negedge clk);
    if (!sf.valid || sdata() != 32768) bad++;
    chk("bp_stable", bad, 0);
    sf.ready = 1'b1;
    h  = cyc;
    wd = 0;
    @(negedge clk);
    while (!sf.valid && wd < 50) begin
      @(negedge clk);
      wd++;
    end
    chk("bp_spacing", cyc - h, 5);
    chk("bp_data2", sdata(), 0);
    @(negedge clk);
    chk("bp_done", int'(ramp_done), 1);

    // Reset while EMIT is stalled
    send(65536, 1000, 2);
    sf.ready = 1'b0;
    chk("mr_valid", int'(sf.valid), 1);
    chk("mr_data", sdata(), 1000);
    reset = 1'b1;
    @(negedge clk);
    chk("mr_rst_valid", int'(sf.valid), 1);
    chk("mr_rst_data", sdata(), 65536);
    chk("mr_rst_done", int'(ramp_done), 0);
    reset    = 1'b0;
    sf.ready = 1'b1;
    @(negedge clk);
    chk("mr_idle_valid", int'(sf.valid), 0);
    chk("mr_idle_busy", int'(busy), 0);
    chk("mr_idle_done", int'(ramp_done), 0);

    // current must be back at 1.0: same target is a no-op
    send(65536, 1000, 2);
    seen = 0;
    repeat (5) begin
      if (sf.valid || ramp_done) seen++;
      @(negedge clk);
    end
    chk("mr_current", seen, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
